// File: rtl/candidate_counter_pkg.sv
// Shared types and helpers for the multi-lane key-space candidate counter.
package candidate_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned MAX_LANES = 16;

   // Distance between the lane-0 values of consecutive beats.
   function automatic longint unsigned beat_stride(input int unsigned lanes,
                                                   input int unsigned step);
      return 64'(lanes) * 64'(step);
   endfunction

   function automatic logic [4:0] popcount(input logic [MAX_LANES-1:0] mask);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         n = n + {4'd0, mask[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/candidate_counter_lane_mask_gen.sv
// Per-lane candidate values and validity mask for one beat starting at base.
module lane_mask_gen #(
   parameter int WIDTH = 32,
   parameter int LANES = 4,
   parameter int STEP  = 1
) (
   input  logic [WIDTH:0]         base,
   input  logic [WIDTH-1:0]       range_end,
   output logic [LANES*WIDTH-1:0] value,
   output logic [LANES-1:0]       mask
);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam logic [WIDTH:0] LANE_OFFSET = (WIDTH+1)'(i * STEP);
      logic [WIDTH:0] offset;

      // The extra top bit keeps lanes past the all-ones value from wrapping into range.
      assign offset                    = base + LANE_OFFSET;
      assign value[i*WIDTH +: WIDTH]   = offset[WIDTH-1:0];
      assign mask[i]                   = (offset <= {1'b0, range_end});
   end

endmodule

// File: rtl/candidate_counter.sv
// Walks an inclusive key range and issues LANES candidates per beat over valid/ready.
module candidate_counter
   import candidate_counter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int LANES = 4,
   parameter int STEP  = 1
) (
   input  logic                   CLK,
   input  logic                   resetn,
   input  logic                   start,
   input  logic                   abort,
   input  logic [WIDTH-1:0]       range_start,
   input  logic [WIDTH-1:0]       range_end,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] out_value,
   output logic [LANES-1:0]       out_mask,
   output logic                   running,
   output logic                   done,
   output logic [WIDTH:0]         issued_count,
   output logic [1:0]             dbg_state
);

   localparam logic [WIDTH:0] BEAT_STRIDE = (WIDTH+1)'(beat_stride(LANES, STEP));

   // Handshake: a beat transfers on a rising edge where out_valid && out_ready;
   // out_value/out_mask are held unchanged while out_valid && !out_ready.
   state_e                 state;
   logic [WIDTH:0]         base;
   logic [WIDTH-1:0]       end_q;
   logic [WIDTH:0]         next_base;
   logic                   accept;
   logic                   start_ok;
   logic                   last_beat;
   logic [WIDTH:0]         gen_base;
   logic [WIDTH-1:0]       gen_end;
   logic [LANES*WIDTH-1:0] gen_value;
   logic [LANES-1:0]       gen_mask;

   assign out_valid = (state == RUN);
   assign running   = (state == RUN);
   assign done      = (state == DONE);
   assign dbg_state = state;

   assign next_base = base + BEAT_STRIDE;
   assign accept    = out_valid && out_ready;
   assign start_ok  = start && (state != RUN);
   assign last_beat = next_base[WIDTH] || (next_base > {1'b0, end_q});

   // One generator serves both the first beat (from the inputs) and every following beat.
   assign gen_base = start_ok ? {1'b0, range_start} : next_base;
   assign gen_end  = start_ok ? range_end : end_q;

   lane_mask_gen #(
      .WIDTH (WIDTH),
      .LANES (LANES),
      .STEP  (STEP)
   ) u_lane_mask_gen (
      .base      (gen_base),
      .range_end (gen_end),
      .value     (gen_value),
      .mask      (gen_mask)
   );

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         base         <= '0;
         end_q        <= '0;
         out_value    <= '0;
         out_mask     <= '0;
         issued_count <= '0;
      end else if (abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  base         <= {1'b0, range_start};
                  end_q        <= range_end;
                  out_value    <= gen_value;
                  out_mask     <= gen_mask;
                  issued_count <= '0;
                  state        <= (range_start > range_end) ? DONE : RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  issued_count <= issued_count
                                + (WIDTH+1)'(popcount(MAX_LANES'(out_mask)));
                  if (last_beat) begin
                     state <= DONE;
                  end else begin
                     base      <= next_base;
                     out_value <= gen_value;
                     out_mask  <= gen_mask;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_candidate_counter.sv
// Self-checking bench for candidate_counter with a beat scoreboard (WIDTH=32, LANES=4, STEP=1).
module tb_candidate_counter;
   import candidate_counter_pkg::*;

   localparam int W = 32;
   localparam int L = 4;
   localparam int S = 1;
   localparam int BW = L*W + L;

   logic             clk;
   logic             resetn;
   logic             start;
   logic             abort;
   logic [W-1:0]     range_start;
   logic [W-1:0]     range_end;
   logic             out_valid;
   logic             out_ready;
   logic [L*W-1:0]   out_value;
   logic [L-1:0]     out_mask;
   logic             running;
   logic             done;
   logic [W:0]       issued_count;
   logic [1:0]       dbg_state;

   logic [BW-1:0]    exp_q[$];
   logic [W:0]       exp_count;
   int               n_checks;
   int               n_fail;

   candidate_counter #(.WIDTH(W), .LANES(L), .STEP(S)) dut (
      .CLK          (clk),
      .resetn       (resetn),
      .start        (start),
      .abort        (abort),
      .range_start  (range_start),
      .range_end    (range_end),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_value    (out_value),
      .out_mask     (out_mask),
      .running      (running),
      .done         (done),
      .issued_count (issued_count),
      .dbg_state    (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: every beat the range should produce, as {mask, value}.
   task automatic push_expected(input logic [W-1:0] lo, input logic [W-1:0] hi);
      longint b;
      longint v;
      logic [L*W-1:0] val;
      logic [L-1:0]   msk;
      exp_q.delete();
      exp_count = '0;
      b = longint'(lo);
      while (b <= longint'(hi)) begin
         for (int i = 0; i < L; i++) begin
            v = b + longint'(i * S);
            val[i*W +: W] = v[W-1:0];
            msk[i] = (v <= longint'(hi));
            if (msk[i]) exp_count = exp_count + 1'b1;
         end
         exp_q.push_back({msk, val});
         b = b + longint'(L * S);
      end
   endtask

   // Driver: pulse start for one cycle; returns at the negedge after the accepting edge.
   task automatic drive_start(input logic [W-1:0] lo, input logic [W-1:0] hi);
      @(negedge clk);
      range_start = lo;
      range_end   = hi;
      start       = 1'b1;
      push_expected(lo, hi);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      n_checks++; if (out_value !== '0) begin n_fail++; $display("FAIL reset_value: got %h expected 0", out_value); end
      n_checks++; if (out_mask !== '0) begin n_fail++; $display("FAIL reset_mask: got %b expected 0", out_mask); end
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b expected 0", running); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (issued_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", issued_count); end
      n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
   endtask

   // Full-ready walk: beats must appear back to back starting in the cycle after start.
   task automatic test_walk(input string name, input logic [W-1:0] lo, input logic [W-1:0] hi);
      int cyc;
      int beats;
      logic [BW-1:0] got;
      int n_exp;
      out_ready = 1'b1;
      drive_start(lo, hi);
      n_exp = exp_q.size();
      n_checks++; if (out_valid !== 1'b1 || running !== 1'b1) begin
         n_fail++; $display("FAIL %s_first_beat: valid=%b running=%b expected 1 1", name, out_valid, running);
      end
      cyc = 0;
      beats = 0;
      while (!done && cyc < 50) begin
         if (out_valid) begin
            got = {out_mask, out_value};
            beats++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL %s_beat: got %h expected none", name, got);
            end else begin
               if (got !== exp_q[0]) begin
                  n_fail++; $display("FAIL %s_beat: got %h expected %h", name, got, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         @(negedge clk);
         cyc++;
      end
      n_checks++; if (done !== 1'b1 || cyc != n_exp) begin
         n_fail++; $display("FAIL %s_done_timing: done=%b cycles=%0d expected 1 %0d", name, done, cyc, n_exp);
      end
      n_checks++; if (beats != n_exp || exp_q.size() != 0) begin
         n_fail++; $display("FAIL %s_beat_count: got %0d expected %0d", name, beats, n_exp);
      end
      n_checks++; if (issued_count !== exp_count) begin
         n_fail++; $display("FAIL %s_issued: got %0d expected %0d", name, issued_count, exp_count);
      end
      n_checks++; if (out_valid !== 1'b0 || running !== 1'b0) begin
         n_fail++; $display("FAIL %s_idle_after: valid=%b running=%b expected 0 0", name, out_valid, running);
      end
   endtask

   task automatic test_empty_range;
      out_ready = 1'b1;
      drive_start(32'd5, 32'd4);
      n_checks++; if (done !== 1'b1 || out_valid !== 1'b0 || running !== 1'b0) begin
         n_fail++; $display("FAIL empty_flags: done=%b valid=%b running=%b expected 1 0 0", done, out_valid, running);
      end
      n_checks++; if (issued_count !== '0) begin
         n_fail++; $display("FAIL empty_issued: got %0d expected 0", issued_count);
      end
      n_checks++; if (dbg_state !== DONE) begin
         n_fail++; $display("FAIL empty_state: got %0d expected %0d", dbg_state, DONE);
      end
   endtask

   task automatic test_backpressure;
      int cyc;
      int accepted;
      logic prev_valid;
      logic prev_ready;
      logic [BW-1:0] prev_beat;
      logic [BW-1:0] cur;
      out_ready = 1'b0;
      drive_start(32'd0, 32'd7);
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_beat  = '0;
      cyc = 0;
      accepted = 0;
      while (!done && cyc < 60) begin
         cur = {out_mask, out_value};
         if (prev_valid && !prev_ready) begin
            n_checks++;
            if (out_valid !== 1'b1 || cur !== prev_beat) begin
               n_fail++; $display("FAIL stall_hold: got %h expected %h", cur, prev_beat);
            end
         end
         out_ready = (cyc % 2 == 1) || ($urandom_range(0, 3) == 0);
         if (out_valid && out_ready) begin
            accepted++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stall_beat: got %h expected none", cur);
            end else begin
               if (cur !== exp_q[0]) begin
                  n_fail++; $display("FAIL stall_beat: got %h expected %h", cur, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_beat  = cur;
         @(negedge clk);
         cyc++;
      end
      n_checks++; if (done !== 1'b1 || accepted != 2) begin
         n_fail++; $display("FAIL stall_accepts: done=%b accepted=%0d expected 1 2", done, accepted);
      end
      n_checks++; if (issued_count !== exp_count) begin
         n_fail++; $display("FAIL stall_issued: got %0d expected %0d", issued_count, exp_count);
      end
   endtask

   task automatic test_abort_and_reset;
      logic [BW-1:0] got;
      out_ready = 1'b1;
      drive_start(32'd0, 32'd99);
      got = {out_mask, out_value};
      n_checks++; if (out_valid !== 1'b1 || got !== exp_q[0]) begin
         n_fail++; $display("FAIL abort_first_beat: got %h expected %h", got, exp_q[0]);
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_q.delete();
      n_checks++; if (out_valid !== 1'b0 || running !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL abort_flags: valid=%b running=%b done=%b expected 0 0 0", out_valid, running, done);
      end
      n_checks++; if (issued_count !== 33'd4) begin
         n_fail++; $display("FAIL abort_issued: got %0d expected 4", issued_count);
      end
      // New walk, stalled; a start while running must not disturb it.
      out_ready = 1'b0;
      drive_start(32'd200, 32'd299);
      range_start = 32'd50;
      range_end   = 32'd60;
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++; if (out_value[W-1:0] !== 32'd200 || running !== 1'b1 || issued_count !== '0) begin
         n_fail++; $display("FAIL start_in_run: lane0=%0d running=%b issued=%0d expected 200 1 0",
                            out_value[W-1:0], running, issued_count);
      end
      #2 resetn = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0 || running !== 1'b0 || done !== 1'b0 || out_value !== '0 ||
                      out_mask !== '0 || issued_count !== '0) begin
         n_fail++; $display("FAIL async_reset: valid=%b running=%b done=%b value=%h mask=%b issued=%0d expected all 0",
                            out_valid, running, done, out_value, out_mask, issued_count);
      end
      @(negedge clk);
      resetn = 1'b1;
      exp_q.delete();
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      resetn      = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      out_ready   = 1'b0;
      range_start = '0;
      range_end   = '0;
      exp_count   = '0;
      repeat (2) @(negedge clk);
      test_reset();
      resetn = 1'b1;
      test_walk("full", 32'd10, 32'd21);
      test_walk("partial", 32'd10, 32'd15);
      test_walk("top", 32'hFFFF_FFFE, 32'hFFFF_FFFF);
      test_empty_range();
      test_backpressure();
      test_abort_and_reset();
      test_walk("after_reset", 32'd3, 32'd9);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/candidate_counter.md
# candidate_counter

- Parametrised multi-lane successor of the MD5 accelerator's key-space counter.
- Walks an inclusive range [range_start, range_end] and issues LANES consecutive candidates per beat over a valid/ready handshake, with a per-lane validity mask for the final partial beat.
- Exact end-of-range detection uses WIDTH+1-bit arithmetic; a range ending at the all-ones value terminates cleanly instead of wrapping.
- Sits between the AXI-Lite register bank, which supplies the range and start/abort, and the bank of parallel MD5 cores that consume the candidates.

## Interface
Parameters:
- WIDTH, 32, candidate width in bits (≥ 8)
- LANES, 4, candidates issued per beat (power of two, 1..16)
- STEP, 1, stride between adjacent candidates (≥ 1)

Ports:
- CLK  input  1  single clock; all logic rising-edge
- resetn  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; latches range and begins walk
- abort  input  1  one-cycle pulse; stops walk and returns to idle
- range_start  input  WIDTH  first candidate; sampled only on an accepted start
- range_end  input  WIDTH  last candidate, inclusive; sampled only on an accepted start
- out_valid  output  1  beat available
- out_ready  input  1  consumer accepts beat
- out_value  output  LANES*WIDTH  lane i in bits [i*WIDTH +: WIDTH] = base + i*STEP
- out_mask  output  LANES  lane i is valid when base + i*STEP ≤ range_end
- running  output  1  high in RUN
- done  output  1  high in DONE; held until the next start or abort
- issued_count  output  WIDTH+1  total valid lanes accepted since the last start

## Operation
- States:
  - IDLE: reset state.
  - RUN: issuing beats.
  - DONE: range exhausted.
- start in IDLE or DONE:
  - Latch range_start into base (WIDTH+1 bits, top bit 0) and latch range_end.
  - Clear issued_count.
  - If range_start > range_end, go to DONE with issued_count = 0 and no beat.
  - Otherwise go to RUN.
- start in RUN is ignored.
- RUN:
  - out_valid = 1.
  - out_value and out_mask are registered and held stable while out_valid && !out_ready.
  - On acceptance (out_valid && out_ready), issued_count += popcount(out_mask).
  - Next base = base + LANES*STEP, computed in WIDTH+1 bits.
  - If next base > range_end or bit WIDTH is set, go to DONE. Otherwise stay in RUN with the next beat.
- Mask:
  - Lane i offset is computed in WIDTH+1 bits and compared against range_end; no lane may wrap.
  - Lane 0 is always valid in any issued beat.
  - Only the final beat may carry a partial mask.
- Each out_value lane is the low WIDTH bits of its offset. Masked-off lanes still carry their computed value but must be ignored.
- abort in any state: go to IDLE, deassert out_valid, clear done, and hold issued_count. abort has priority over start and over acceptance in the same cycle.
- DONE: out_valid = 0, running = 0, done = 1.

## Timing
- Reset values: out_valid 0, out_value 0, out_mask 0, running 0, done 0, issued_count 0, state IDLE.
- Accepted start at edge n: running and out_valid are high after edge n; the first beat is valid in cycle n+1. For an empty range, done rises after edge n instead.
- Throughput: one beat per cycle while out_ready is held high, with no bubbles.
- Final acceptance at edge m: out_valid falls, done rises and running falls, all after edge m. issued_count is final in the same cycle.
- resetn asserted mid-walk: all outputs return to their reset values immediately and asynchronously. Deassertion is synchronised upstream.

## Structure
- Package candidate_counter_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - localparam helpers for LANES*STEP in WIDTH+1 bits
  - popcount function for a LANES-bit mask
- Sub-module lane_mask_gen (combinational) takes base, range_end, WIDTH, LANES and STEP, and produces the per-lane values and out_mask. The top level owns the FSM, the registers and the handshake.

## Test plan
- WIDTH=32, LANES=4, STEP=1, range [10, 21], out_ready=1 → beats at base 10, 14, 18 with masks 1111, 1111, 1111; then done; issued_count = 12.
- Same config, range [10, 15] → beats 10 (mask 1111), 14 (mask 0011); done; issued_count = 6.
- Range [0xFFFFFFFE, 0xFFFFFFFF] → single beat with lanes 0xFFFFFFFE, 0xFFFFFFFF, mask 0011; done with no wrap; issued_count = 2.
- Range [5, 4] → no out_valid; done one cycle after start; issued_count = 0.
- Backpressure: out_ready toggled 0/1 on range [0, 7] → out_value and out_mask stable while stalled; beats 0 and 4 each accepted exactly once; issued_count = 8.
- abort together with out_ready on the second beat of [0, 99], then resetn pulsed low mid-walk of a new range → IDLE with issued_count = 4 after the abort; all outputs zero asynchronously during reset.
